// File: rtl/burst_trig_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : burst_trig_pkg
// Description : Shared state encoding and default widths for the burst
//               trigger controller.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_trig_pkg;

    localparam int DEF_CNT_W = 16;   // burst cycle counter width
    localparam int DEF_DLY_W = 24;   // delay / holdoff counter width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_BURST   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

endpackage : burst_trig_pkg
`default_nettype wire

// File: rtl/trig_down_cnt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : trig_down_cnt
// Description : Loadable down-counter that saturates at zero.
//               Priority: clear > load > decrement.
// Ports       : clk_i, rst_ni   - clock, async active-low reset
//               clr_i           - synchronous clear to zero
//               load_i/val_i    - load a new count
//               dec_i           - decrement (ignored once at zero)
//               zero_o          - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module trig_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : trig_down_cnt
`default_nettype wire

// File: rtl/burst_trigger_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : burst_trigger_ctrl
// Description : Converts toggle-coded trigger events into a gated waveform
//               burst: programmable start delay, N waveform cycles (or
//               continuous until the next trigger when N=0), then holdoff.
//               Triggers arriving while busy are flagged and dropped.
// Ports       : Clock, Reset_n          - clock, async active-low reset
//               Burst_EN                - enable; low aborts to IDLE
//               Trig_Din                - toggle-coded trigger
//               Cycle_End               - waveform period wrap pulse
//               Burst_Count/Delay_Count/Holdoff_Count - configuration
//               Wave_EN, Busy, Burst_Done, Trig_Missed - status/gating
// Revision    : 1.0 - initial release
// ============================================================================
module burst_trigger_ctrl
    import burst_trig_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DLY_W = DEF_DLY_W
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Burst_EN,
    input  logic             Trig_Din,
    input  logic             Cycle_End,
    input  logic [CNT_W-1:0] Burst_Count,
    input  logic [DLY_W-1:0] Delay_Count,
    input  logic [DLY_W-1:0] Holdoff_Count,
    output logic             Wave_EN,
    output logic             Busy,
    output logic             Burst_Done,
    output logic             Trig_Missed
);

    state_t             state_q, state_d;
    logic               trig_last_q;
    logic [CNT_W-1:0]   burst_sh_q, burst_sh_d;
    logic [DLY_W-1:0]   hold_sh_q, hold_sh_d;
    logic               wave_en_q, wave_en_d;
    logic               done_q, done_d;
    logic               missed_q, missed_d;

    logic               event_w;
    logic               cnt_clr_w;
    logic               dly_load_w, dly_dec_w, dly_zero_w;
    logic [DLY_W-1:0]   dly_val_w;
    logic               cyc_load_w, cyc_dec_w, cyc_zero_w;
    logic [CNT_W-1:0]   cyc_val_w;
    logic               continuous_w;

    assign event_w      = (Trig_Din != trig_last_q);
    assign continuous_w = (burst_sh_q == '0);
    // The cycle counter holds "cycles remaining after the current one", so
    // the burst ends on the Cycle_End seen while it reads zero.
    assign cyc_val_w    = continuous_w ? '0 : (burst_sh_q - CNT_W'(1));

    // Delay and holdoff never overlap, so they share one counter.
    trig_down_cnt #(.W(DLY_W)) u_dly_cnt (
        .clk_i  (Clock),
        .rst_ni (Reset_n),
        .clr_i  (cnt_clr_w),
        .load_i (dly_load_w),
        .val_i  (dly_val_w),
        .dec_i  (dly_dec_w),
        .zero_o (dly_zero_w)
    );

    trig_down_cnt #(.W(CNT_W)) u_cyc_cnt (
        .clk_i  (Clock),
        .rst_ni (Reset_n),
        .clr_i  (cnt_clr_w),
        .load_i (cyc_load_w),
        .val_i  (cyc_val_w),
        .dec_i  (cyc_dec_w),
        .zero_o (cyc_zero_w)
    );

    always_comb begin
        state_d    = state_q;
        burst_sh_d = burst_sh_q;
        hold_sh_d  = hold_sh_q;
        done_d     = 1'b0;
        missed_d   = 1'b0;
        cnt_clr_w  = 1'b0;
        dly_load_w = 1'b0;
        dly_val_w  = '0;
        dly_dec_w  = 1'b0;
        cyc_load_w = 1'b0;
        cyc_dec_w  = 1'b0;

        if (!Burst_EN) begin
            // Silent abort: no done/missed flags, events discarded.
            state_d    = ST_IDLE;
            cnt_clr_w  = 1'b1;
            burst_sh_d = '0;
            hold_sh_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (event_w) begin
                        state_d    = ST_DELAY;
                        dly_load_w = 1'b1;
                        dly_val_w  = Delay_Count;
                        burst_sh_d = Burst_Count;
                        hold_sh_d  = Holdoff_Count;
                    end
                end
                ST_DELAY: begin
                    missed_d = event_w;
                    if (dly_zero_w) begin
                        state_d    = ST_BURST;
                        cyc_load_w = 1'b1;
                    end else begin
                        dly_dec_w = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (continuous_w) begin
                        // The stop event is consumed, not reported as missed.
                        if (event_w) begin
                            state_d    = ST_HOLDOFF;
                            done_d     = 1'b1;
                            dly_load_w = 1'b1;
                            dly_val_w  = hold_sh_q;
                        end
                    end else begin
                        missed_d = event_w;
                        if (Cycle_End) begin
                            if (cyc_zero_w) begin
                                state_d    = ST_HOLDOFF;
                                done_d     = 1'b1;
                                dly_load_w = 1'b1;
                                dly_val_w  = hold_sh_q;
                            end else begin
                                cyc_dec_w = 1'b1;
                            end
                        end
                    end
                end
                ST_HOLDOFF: begin
                    missed_d = event_w;
                    if (dly_zero_w) begin
                        state_d = ST_IDLE;
                    end else begin
                        dly_dec_w = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wave_en_d = (state_d == ST_BURST);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            trig_last_q <= 1'b0;
            burst_sh_q  <= '0;
            hold_sh_q   <= '0;
            wave_en_q   <= 1'b0;
            done_q      <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_last_q <= Trig_Din;  // tracked even while disabled
            burst_sh_q  <= burst_sh_d;
            hold_sh_q   <= hold_sh_d;
            wave_en_q   <= wave_en_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
        end
    end

    assign Wave_EN     = wave_en_q;
    assign Busy        = (state_q != ST_IDLE);
    assign Burst_Done  = done_q;
    assign Trig_Missed = missed_q;

endmodule : burst_trigger_ctrl
`default_nettype wire

// File: tb/tb_burst_trigger_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_burst_trigger_ctrl
// Description : Directed self-checking bench for burst_trigger_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_trigger_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic        Burst_EN;
    logic        Trig_Din;
    logic        Cycle_End;
    logic [15:0] Burst_Count;
    logic [23:0] Delay_Count;
    logic [23:0] Holdoff_Count;
    logic        Wave_EN;
    logic        Busy;
    logic        Burst_Done;
    logic        Trig_Missed;

    burst_trigger_ctrl #(.CNT_W(16), .DLY_W(24)) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Burst_EN      (Burst_EN),
        .Trig_Din      (Trig_Din),
        .Cycle_End     (Cycle_End),
        .Burst_Count   (Burst_Count),
        .Delay_Count   (Delay_Count),
        .Holdoff_Count (Holdoff_Count),
        .Wave_EN       (Wave_EN),
        .Busy          (Busy),
        .Burst_Done    (Burst_Done),
        .Trig_Missed   (Trig_Missed)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks, failures;
    int edge_n, acc_edge, rise_edge, fall_edge, idle_edge, done_edge;
    int done_cnt, missed_cnt, ce_burst, ce_period, ce_phase;
    logic prev_we, prev_busy;

    // One clock; inputs change and outputs are observed 1ns after the edge.
    task automatic step();
        if (Wave_EN && Cycle_End) ce_burst++;
        prev_we   = Wave_EN;
        prev_busy = Busy;
        @(posedge Clock);
        #1;
        edge_n++;
        if (Burst_Done) begin done_cnt++; done_edge = edge_n; end
        if (Trig_Missed) missed_cnt++;
        if (!prev_we && Wave_EN) rise_edge = edge_n;
        if (prev_we && !Wave_EN) fall_edge = edge_n;
        if (prev_busy && !Busy) idle_edge = edge_n;
        if (ce_period != 0) begin
            ce_phase++;
            Cycle_End = ((ce_phase % ce_period) == 0);
        end
    endtask

    task automatic clear_obs();
        rise_edge = -1; fall_edge = -1; idle_edge = -1; done_edge = -1;
        done_cnt = 0; missed_cnt = 0; ce_burst = 0;
    endtask

    task automatic trigger();
        Trig_Din = ~Trig_Din;
        acc_edge = edge_n + 1;
    endtask

    task automatic wait_we(input logic val, input int max);
        int n = 0;
        while (Wave_EN !== val && n < max) begin step(); n++; end
        if (Wave_EN !== val) begin
            checks++; failures++;
            $display("FAIL wait_wave_en actual=%b required=%b (timeout)", Wave_EN, val);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (Busy !== 1'b0 && n < max) begin step(); n++; end
        if (Busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL wait_idle actual=%b required=0 (timeout)", Busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({Wave_EN, Busy, Burst_Done, Trig_Missed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=0000",
                     {Wave_EN, Busy, Burst_Done, Trig_Missed});
        end
        Reset_n = 1'b1;
        step();
    endtask

    // Delay=5, Burst=3, Holdoff=4, Cycle_End every 10 clocks.
    task automatic test_single_burst();
        Delay_Count = 24'd5; Burst_Count = 16'd3; Holdoff_Count = 24'd4;
        ce_period = 10;
        clear_obs();
        trigger();
        step();
        checks++;
        if (Busy !== 1'b1) begin
            failures++; $display("FAIL single_busy actual=%b required=1", Busy);
        end
        wait_we(1'b1, 20);
        checks++;
        if (rise_edge != acc_edge + 6) begin
            failures++; $display("FAIL single_rise actual=%0d required=%0d", rise_edge, acc_edge + 6);
        end
        wait_we(1'b0, 100);
        checks++;
        if (ce_burst != 3) begin
            failures++; $display("FAIL single_cycles actual=%0d required=3", ce_burst);
        end
        checks++;
        if (done_cnt != 1 || done_edge != fall_edge) begin
            failures++;
            $display("FAIL single_done count=%0d edge=%0d required count=1 edge=%0d",
                     done_cnt, done_edge, fall_edge);
        end
        wait_idle(20);
        checks++;
        if (idle_edge != fall_edge + 5) begin
            failures++; $display("FAIL single_idle actual=%0d required=%0d", idle_edge, fall_edge + 5);
        end
        checks++;
        if (missed_cnt != 0) begin
            failures++; $display("FAIL single_missed actual=%0d required=0", missed_cnt);
        end
    endtask

    task automatic test_continuous();
        Delay_Count = 24'd0; Burst_Count = 16'd0; Holdoff_Count = 24'd2;
        ce_period = 3; ce_phase = 0;
        clear_obs();
        trigger();
        wait_we(1'b1, 5);
        checks++;
        if (rise_edge != acc_edge + 1) begin
            failures++; $display("FAIL cont_rise actual=%0d required=%0d", rise_edge, acc_edge + 1);
        end
        repeat (60) step();
        checks++;
        if (Wave_EN !== 1'b1 || fall_edge != -1 || ce_burst < 20) begin
            failures++;
            $display("FAIL cont_hold wave=%b fall=%0d ce=%0d required wave=1 fall=-1 ce>=20",
                     Wave_EN, fall_edge, ce_burst);
        end
        ce_period = 0;
        Cycle_End = 1'b1;
        trigger();
        step();
        Cycle_End = 1'b0;
        checks++;
        if ({Wave_EN, Burst_Done, Trig_Missed} !== 3'b010) begin
            failures++;
            $display("FAIL cont_stop actual=%b required=010", {Wave_EN, Burst_Done, Trig_Missed});
        end
        checks++;
        if (fall_edge != acc_edge) begin
            failures++; $display("FAIL cont_fall actual=%0d required=%0d", fall_edge, acc_edge);
        end
        wait_idle(10);
        checks++;
        if (idle_edge != fall_edge + 3 || missed_cnt != 0) begin
            failures++;
            $display("FAIL cont_idle edge=%0d missed=%0d required edge=%0d missed=0",
                     idle_edge, missed_cnt, fall_edge + 3);
        end
    endtask

    task automatic test_missed();
        Delay_Count = 24'd3; Burst_Count = 16'd2; Holdoff_Count = 24'd3;
        ce_period = 4; ce_phase = 0; Cycle_End = 1'b0;
        clear_obs();
        trigger();
        step(); step();
        trigger();                 // lands in DELAY
        wait_we(1'b1, 10);
        step();
        trigger();                 // lands in BURST
        wait_we(1'b0, 30);
        step();
        trigger();                 // lands in HOLDOFF
        wait_idle(20);
        checks++;
        if (missed_cnt != 3) begin
            failures++; $display("FAIL missed_count actual=%0d required=3", missed_cnt);
        end
        checks++;
        if (ce_burst != 2) begin
            failures++; $display("FAIL missed_cycles actual=%0d required=2", ce_burst);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++; $display("FAIL missed_done actual=%0d required=1", done_cnt);
        end
    endtask

    task automatic test_shadow();
        Delay_Count = 24'd1; Burst_Count = 16'd3; Holdoff_Count = 24'd1;
        ce_period = 5; ce_phase = 0;
        clear_obs();
        trigger();
        wait_we(1'b1, 10);
        step(); step();
        Burst_Count = 16'd7;
        wait_we(1'b0, 40);
        checks++;
        if (ce_burst != 3) begin
            failures++; $display("FAIL shadow_first actual=%0d required=3", ce_burst);
        end
        wait_idle(10);
        clear_obs();
        trigger();
        wait_we(1'b1, 10);
        wait_we(1'b0, 60);
        checks++;
        if (ce_burst != 7) begin
            failures++; $display("FAIL shadow_second actual=%0d required=7", ce_burst);
        end
        wait_idle(10);
        checks++;
        if (done_cnt != 1 || missed_cnt != 0) begin
            failures++;
            $display("FAIL shadow_flags done=%0d missed=%0d required done=1 missed=0",
                     done_cnt, missed_cnt);
        end
    endtask

    task automatic test_simultaneous();
        Delay_Count = 24'd0; Burst_Count = 16'd1; Holdoff_Count = 24'd0;
        ce_period = 0; Cycle_End = 1'b0;
        clear_obs();
        trigger();
        wait_we(1'b1, 5);
        step();
        Cycle_End = 1'b1;
        trigger();
        step();
        Cycle_End = 1'b0;
        checks++;
        if ({Wave_EN, Burst_Done, Trig_Missed} !== 3'b011) begin
            failures++;
            $display("FAIL simul_end actual=%b required=011", {Wave_EN, Burst_Done, Trig_Missed});
        end
        wait_idle(5);
        checks++;
        if (idle_edge != fall_edge + 1) begin
            failures++; $display("FAIL simul_idle actual=%0d required=%0d", idle_edge, fall_edge + 1);
        end
    endtask

    task automatic test_disable();
        Delay_Count = 24'd0; Burst_Count = 16'd4; Holdoff_Count = 24'd2;
        ce_period = 5; ce_phase = 0;
        clear_obs();
        trigger();
        wait_we(1'b1, 5);
        step(); step();
        Burst_EN = 1'b0;
        step();
        checks++;
        if ({Wave_EN, Busy, Burst_Done, Trig_Missed} !== 4'b0000) begin
            failures++;
            $display("FAIL disable_abort actual=%b required=0000",
                     {Wave_EN, Busy, Burst_Done, Trig_Missed});
        end
        trigger();
        step(); step();
        checks++;
        if (Busy !== 1'b0 || missed_cnt != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL disable_event busy=%b missed=%0d done=%0d required 0/0/0",
                     Busy, missed_cnt, done_cnt);
        end
        Burst_EN = 1'b1;
        repeat (5) step();
        checks++;
        if (Busy !== 1'b0 || Wave_EN !== 1'b0 || missed_cnt != 0) begin
            failures++;
            $display("FAIL reenable_idle busy=%b wave=%b missed=%0d required 0/0/0",
                     Busy, Wave_EN, missed_cnt);
        end
    endtask

    task automatic test_reset_mid();
        Delay_Count = 24'd10; Burst_Count = 16'd3; Holdoff_Count = 24'd4;
        ce_period = 10;
        clear_obs();
        trigger();
        step(); step();
        checks++;
        if (Busy !== 1'b1) begin
            failures++; $display("FAIL rst_delay_pre actual=%b required=1", Busy);
        end
        Reset_n = 1'b0; Trig_Din = 1'b0;
        #2;
        checks++;
        if ({Wave_EN, Busy, Burst_Done, Trig_Missed} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_delay actual=%b required=0000",
                     {Wave_EN, Busy, Burst_Done, Trig_Missed});
        end
        step();
        Reset_n = 1'b1;
        step();
        Delay_Count = 24'd0;
        trigger();
        wait_we(1'b1, 5);
        step(); step();
        Reset_n = 1'b0; Trig_Din = 1'b0;
        #2;
        checks++;
        if ({Wave_EN, Busy, Burst_Done, Trig_Missed} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_burst actual=%b required=0000",
                     {Wave_EN, Busy, Burst_Done, Trig_Missed});
        end
        step();
        Reset_n = 1'b1;
        step(); step();
        test_single_burst();
    endtask

    initial begin
        checks = 0; failures = 0; edge_n = 0; acc_edge = 0;
        ce_period = 0; ce_phase = 0;
        Reset_n = 1'b0; Burst_EN = 1'b1; Trig_Din = 1'b0; Cycle_End = 1'b0;
        Burst_Count = '0; Delay_Count = '0; Holdoff_Count = '0;
        clear_obs();
        #2;
        test_reset();
        test_single_burst();
        test_continuous();
        test_missed();
        test_shadow();
        test_simultaneous();
        test_disable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_burst_trigger_ctrl
`default_nettype wire
